// File: rtl/hps_rst_pkg.sv
// Shared types and the key priority encoder for the HPS reset-request controller.
package hps_rst_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        CAUSE_NONE  = 3'd0,
        CAUSE_COLD  = 3'd1,
        CAUSE_WARM  = 3'd2,
        CAUSE_DEBUG = 3'd3,
        CAUSE_WDOG  = 3'd4
    } cause_e;

    // Cold beats warm beats debug when presses land on the same cycle.
    function automatic cause_e prio_encode(input logic cold, input logic warm, input logic debug);
        if (cold)  return CAUSE_COLD;
        if (warm)  return CAUSE_WARM;
        if (debug) return CAUSE_DEBUG;
        return CAUSE_NONE;
    endfunction

endpackage

// File: rtl/hps_rst_debounce.sv
// One pushbutton: 2-flop synchroniser, debounce counter and registered press (1->0) pulse.
module hps_rst_debounce
    import hps_rst_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_key_n,
    output logic o_press
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       r_sync;
    logic             r_deb;
    logic [CNT_W-1:0] r_cnt;
    logic             r_press;

    // Everything resets to the released level so reset exit never looks like a press.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync  <= 2'b11;
            r_deb   <= 1'b1;
            r_cnt   <= '0;
            r_press <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_key_n};
            r_press <= 1'b0;
            if (r_sync[1] == r_deb) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_cnt   <= '0;
                r_deb   <= r_sync[1];
                r_press <= ~r_sync[1];
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/hps_reset_req_ctrl.sv
// Debounces three reset keys and issues prioritised f2h reset-request pulses with hold-off.
// Optional heartbeat watchdog is built in when HPS_RST_WDOG_EN is defined.
module hps_reset_req_ctrl
    import hps_rst_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned PULSE_CYCLES    = 256,
    parameter int unsigned HOLDOFF_CYCLES  = 1024,
    parameter int unsigned WDOG_CYCLES     = 2**24
) (
    input  logic       clk_clk,
    input  logic       reset_reset,
    input  logic       key_cold_n,
    input  logic       key_warm_n,
    input  logic       key_debug_n,
    input  logic       heartbeat_i,
    output logic       f2h_cold_reset_req_n,
    output logic       f2h_warm_reset_req_n,
    output logic       f2h_debug_reset_req_n,
    output logic       busy,
    output logic [2:0] last_cause
);

    localparam int unsigned MAX_CYC = (PULSE_CYCLES > HOLDOFF_CYCLES) ? PULSE_CYCLES : HOLDOFF_CYCLES;
    localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLDOFF_CYCLES - 1);

    logic w_press_cold;
    logic w_press_warm;
    logic w_press_debug;
    logic w_any_press;
    logic w_wdog_expire;

    state_e           r_state;
    state_e           w_state_d;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_d;
    cause_e           r_cause;
    cause_e           w_cause_d;

    logic r_cold_n;
    logic r_warm_n;
    logic r_debug_n;
    logic r_busy;
    logic w_cold_n_d;
    logic w_warm_n_d;
    logic w_debug_n_d;
    logic w_busy_d;

    hps_rst_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_cold (
        .i_clk(clk_clk), .i_rst(reset_reset), .i_key_n(key_cold_n), .o_press(w_press_cold)
    );
    hps_rst_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_warm (
        .i_clk(clk_clk), .i_rst(reset_reset), .i_key_n(key_warm_n), .o_press(w_press_warm)
    );
    hps_rst_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_debug (
        .i_clk(clk_clk), .i_rst(reset_reset), .i_key_n(key_debug_n), .o_press(w_press_debug)
    );

    assign w_any_press = w_press_cold | w_press_warm | w_press_debug;

`ifdef HPS_RST_WDOG_EN
    localparam int unsigned WD_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_CYCLES - 1);

    logic [2:0]      r_hb_sync;
    logic [WD_W-1:0] r_wdog_cnt;
    logic            w_hb_edge;

    assign w_hb_edge     = r_hb_sync[1] ^ r_hb_sync[2];
    assign w_wdog_expire = (r_state == ST_IDLE) && (r_wdog_cnt == WD_LAST) && !w_hb_edge;

    // Watchdog only runs while idle; any heartbeat edge is a kick.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_hb_sync  <= '0;
            r_wdog_cnt <= '0;
        end else begin
            r_hb_sync <= {r_hb_sync[1:0], heartbeat_i};
            if ((r_state != ST_IDLE) || w_hb_edge || (r_wdog_cnt == WD_LAST)) begin
                r_wdog_cnt <= '0;
            end else begin
                r_wdog_cnt <= r_wdog_cnt + WD_W'(1);
            end
        end
    end
`else
    logic        w_unused_hb;
    logic [31:0] w_unused_wdog;
    assign w_unused_hb   = heartbeat_i;
    assign w_unused_wdog = 32'(WDOG_CYCLES);
    assign w_wdog_expire = 1'b0;
`endif

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_cause <= CAUSE_NONE;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_cause <= w_cause_d;
        end
    end

    // Next state; one shared down-counter times both the pulse and the hold-off.
    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_cause_d = r_cause;
        case (r_state)
            ST_IDLE: begin
                if (w_any_press) begin
                    w_state_d = ST_ASSERT;
                    w_cnt_d   = PULSE_LOAD;
                    w_cause_d = prio_encode(w_press_cold, w_press_warm, w_press_debug);
                end else if (w_wdog_expire) begin
                    w_state_d = ST_ASSERT;
                    w_cnt_d   = PULSE_LOAD;
                    w_cause_d = CAUSE_WDOG;
                end
            end
            ST_ASSERT: begin
                if (w_press_cold && (r_cause != CAUSE_COLD)) begin
                    w_cnt_d   = PULSE_LOAD;
                    w_cause_d = CAUSE_COLD;
                end else if (r_cnt == '0) begin
                    w_state_d = ST_HOLDOFF;
                    w_cnt_d   = HOLD_LOAD;
                end else begin
                    w_cnt_d = r_cnt - CNT_W'(1);
                end
            end
            ST_HOLDOFF: begin
                if (r_cnt == '0) begin
                    w_state_d = ST_IDLE;
                end else begin
                    w_cnt_d = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_d = ST_IDLE;
                w_cnt_d   = '0;
            end
        endcase
    end

    // Output decode from the next state so the request lines switch on the same edge as the FSM.
    always_comb begin
        w_cold_n_d  = 1'b1;
        w_warm_n_d  = 1'b1;
        w_debug_n_d = 1'b1;
        w_busy_d    = (w_state_d != ST_IDLE);
        if (w_state_d == ST_ASSERT) begin
            w_cold_n_d  = (w_cause_d != CAUSE_COLD);
            w_warm_n_d  = !((w_cause_d == CAUSE_WARM) || (w_cause_d == CAUSE_WDOG));
            w_debug_n_d = (w_cause_d != CAUSE_DEBUG);
        end
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_cold_n  <= 1'b1;
            r_warm_n  <= 1'b1;
            r_debug_n <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            r_cold_n  <= w_cold_n_d;
            r_warm_n  <= w_warm_n_d;
            r_debug_n <= w_debug_n_d;
            r_busy    <= w_busy_d;
        end
    end

    assign f2h_cold_reset_req_n  = r_cold_n;
    assign f2h_warm_reset_req_n  = r_warm_n;
    assign f2h_debug_reset_req_n = r_debug_n;
    assign busy                  = r_busy;
    assign last_cause            = r_cause;

endmodule

// File: tb/tb_hps_reset_req_ctrl.sv
// Directed plus random bench for hps_reset_req_ctrl against a cycle-count reference model.
module tb_hps_reset_req_ctrl;

    localparam int unsigned D = 4;
    localparam int unsigned P = 8;
    localparam int unsigned H = 16;
    localparam int unsigned W = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_cold_n = 1'b1;
    logic       key_warm_n = 1'b1;
    logic       key_debug_n = 1'b1;
    logic       hb = 1'b0;
    logic       cold_n;
    logic       warm_n;
    logic       debug_n;
    logic       busy;
    logic [2:0] last_cause;

    int total = 0;
    int bad   = 0;

    // Reference model: remaining pulse / hold-off cycles and raw sample history.
    int unsigned m_pl;
    int unsigned m_hl;
    int unsigned m_wd;
    int unsigned m_cause;
    logic [2:0]  m_deb;
    logic [2:0]  m_press;
    logic [2:0]  m_kh [0:7];
    logic        m_hh [0:3];

    always #5 clk = ~clk;

    hps_reset_req_ctrl #(
        .DEBOUNCE_CYCLES(D), .PULSE_CYCLES(P), .HOLDOFF_CYCLES(H), .WDOG_CYCLES(W)
    ) dut (
        .clk_clk(clk), .reset_reset(rst),
        .key_cold_n(key_cold_n), .key_warm_n(key_warm_n), .key_debug_n(key_debug_n),
        .heartbeat_i(hb),
        .f2h_cold_reset_req_n(cold_n), .f2h_warm_reset_req_n(warm_n),
        .f2h_debug_reset_req_n(debug_n), .busy(busy), .last_cause(last_cause)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pl = 0; m_hl = 0; m_wd = 0; m_cause = 0;
        m_deb = 3'b111; m_press = 3'b000;
        for (int i = 0; i < 8; i++) m_kh[i] = 3'b111;
        for (int i = 0; i < 4; i++) m_hh[i] = 1'b0;
    endtask

    // One clock edge of the model; keys are {cold, warm, debug}.
    task automatic model_step();
        logic       idle;
        logic       hbe;
        logic [2:0] flip;
        idle = (m_pl == 0) && (m_hl == 0);
        hbe  = m_hh[1] ^ m_hh[2];
        if (m_pl > 0) begin
            if (m_press[2] && m_cause != 1) begin
                m_cause = 1; m_pl = P;
            end else begin
                m_pl--;
                if (m_pl == 0) m_hl = H;
            end
        end else if (m_hl > 0) begin
            m_hl--;
        end else if (m_press != 3'b000) begin
            m_cause = m_press[2] ? 1 : (m_press[1] ? 2 : 3);
            m_pl = P;
        end
`ifdef HPS_RST_WDOG_EN
        else if (m_wd == W - 1 && !hbe) begin
            m_cause = 4; m_pl = P;
        end
        if (!idle || hbe || m_wd == W - 1) m_wd = 0;
        else m_wd++;
`else
        if (idle && hbe) m_wd = 0;
`endif
        // A key level is accepted once D consecutive synced samples disagree with it.
        for (int b = 0; b < 3; b++) begin
            flip[b] = 1'b1;
            for (int a = 1; a <= int'(D); a++)
                if (m_kh[a][b] == m_deb[b]) flip[b] = 1'b0;
        end
        m_press = flip & m_deb;
        m_deb   = m_deb ^ flip;
        for (int a = 7; a > 0; a--) m_kh[a] = m_kh[a-1];
        m_kh[0] = {key_cold_n, key_warm_n, key_debug_n};
        for (int a = 3; a > 0; a--) m_hh[a] = m_hh[a-1];
        m_hh[0] = hb;
    endtask

    task automatic check_all();
        chk("cold_req_n",  32'(cold_n),  32'(!(m_pl > 0 && m_cause == 1)));
        chk("warm_req_n",  32'(warm_n),  32'(!(m_pl > 0 && (m_cause == 2 || m_cause == 4))));
        chk("debug_req_n", 32'(debug_n), 32'(!(m_pl > 0 && m_cause == 3)));
        chk("busy",        32'(busy),    32'(m_pl > 0 || m_hl > 0));
        chk("last_cause",  32'(last_cause), 32'(m_cause));
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else model_step();
        #1;
        check_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        model_reset();
        run(3);
        rst = 1'b0;
        run(10);

        // Single warm press held 20 samples: pulse after edge 7, busy 24 cycles.
        key_warm_n = 1'b0; run(20);
        key_warm_n = 1'b1; run(30);

        // Cold glitch shorter than the debounce window.
        key_cold_n = 1'b0; run(3);
        key_cold_n = 1'b1; run(20);

        // Debug and warm together, then cold escalates 3 cycles into the warm pulse.
        key_warm_n = 1'b0; key_debug_n = 1'b0; run(3);
        key_cold_n = 1'b0; run(10);
        key_cold_n = 1'b1; key_warm_n = 1'b1; key_debug_n = 1'b1; run(50);

        // Second warm press lands in hold-off, third after return to idle.
        key_warm_n = 1'b0; run(10);
        key_warm_n = 1'b1; run(4);
        key_warm_n = 1'b0; run(10);
        key_warm_n = 1'b1; run(16);
        key_warm_n = 1'b0; run(10);
        key_warm_n = 1'b1; run(40);

        // Key held through the whole sequence must not retrigger.
        key_debug_n = 1'b0; run(70);
        key_debug_n = 1'b1; run(40);

        // Reset mid-pulse drops the request without waiting for a clock edge.
        key_cold_n = 1'b0; run(12);
        #2; rst = 1'b1;
        #1; model_reset(); check_all();
        key_cold_n = 1'b1;
        run(3);
        rst = 1'b0;
        run(30);

        // Heartbeat kicked every 30 cycles, then left alone.
        for (int i = 0; i < 10; i++) begin
            hb = ~hb; run(30);
        end
        run(200);

        // Random key and heartbeat activity.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(9, 0) == 0) key_cold_n  = ~key_cold_n;
            if ($urandom_range(7, 0) == 0) key_warm_n  = ~key_warm_n;
            if ($urandom_range(7, 0) == 0) key_debug_n = ~key_debug_n;
            if ($urandom_range(39, 0) == 0) hb = ~hb;
            tick();
        end
        key_cold_n = 1'b1; key_warm_n = 1'b1; key_debug_n = 1'b1;
        run(60);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
